// File: rtl/edge_line_cache.sv
// edge_line_cache: direct-mapped cache that looks up adjacency-matrix edge
// weights. Each query resolves in a hit/out-of-range path of two cycles, or
// in a miss path that reads the weight from memory and fills the line.
// Optional feature: define EDGE_CACHE_STATS_EN to add saturating hit/miss counters.

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 256
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module edge_line_cache #(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int LINES       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] base_address,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic                   flush,
    input  logic                   query_enable,
    input  logic [INDEX_WIDTH-1:0] from_node,
    input  logic [INDEX_WIDTH-1:0] to_node,
    output logic                   query_ready,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic [MDATA_WIDTH-1:0] mem_data,
    output logic                   mem_read_enable,
    input  logic                   mem_read_ready,
    output logic                   ready,
    output logic [VALUE_WIDTH-1:0] edge_value
`ifdef EDGE_CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);

    localparam int LINE_BITS  = $clog2(LINES);
    localparam int EDGE_WIDTH = 2 * INDEX_WIDTH;

    // MAX_NODES documents the supported graph size; the index width bounds it.
    localparam int unused_max_nodes = MAX_NODES;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FETCH,
        RESPOND
    } state_t;

    state_t                 state;
    logic [EDGE_WIDTH-1:0]  req_index;
    logic                   req_out_of_range;
    logic [MADDR_WIDTH-1:0] stored_base;
    logic [INDEX_WIDTH-1:0] stored_nodes;
    logic [LINES-1:0]       line_valid;
    logic [EDGE_WIDTH-1:0]  line_tag  [LINES];
    logic [VALUE_WIDTH-1:0] line_data [LINES];
    logic                   fill_cancelled;

    logic                   accept;
    logic                   config_changed;
    logic                   lookup_hit;
    logic                   fill_write;
    logic [EDGE_WIDTH-1:0]  new_index;
    logic                   new_out_of_range;
    logic [LINE_BITS-1:0]   req_line;
    logic [MDATA_WIDTH-1:0] unused_mem_data;

    assign unused_mem_data  = mem_data;
    assign query_ready      = (state == IDLE);
    assign accept           = query_enable && query_ready;
    assign new_index        = EDGE_WIDTH'(from_node) * EDGE_WIDTH'(number_of_nodes)
                            + EDGE_WIDTH'(to_node);
    assign new_out_of_range = (from_node >= number_of_nodes) || (to_node >= number_of_nodes);
    assign config_changed   = (base_address != stored_base) || (number_of_nodes != stored_nodes);
    assign req_line         = req_index[LINE_BITS-1:0];
    assign lookup_hit       = line_valid[req_line] && (line_tag[req_line] == req_index);
    // A flush seen at any point of the fetch, including the completing edge, blocks the fill.
    assign fill_write       = (state == FETCH) && mem_read_ready && !flush && !fill_cancelled;

    // Query sequencing, memory handshake, result registers and line valid bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            req_index        <= '0;
            req_out_of_range <= 1'b0;
            stored_base      <= '0;
            stored_nodes     <= '0;
            line_valid       <= '0;
            fill_cancelled   <= 1'b0;
            mem_addr         <= '0;
            mem_read_enable  <= 1'b0;
            ready            <= 1'b0;
            edge_value       <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_index        <= new_index;
                        req_out_of_range <= new_out_of_range;
                        stored_base      <= base_address;
                        stored_nodes     <= number_of_nodes;
                        state            <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_out_of_range) begin
                        edge_value <= '1;
                        ready      <= 1'b1;
                        state      <= RESPOND;
                    end else if (lookup_hit) begin
                        edge_value <= line_data[req_line];
                        ready      <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        mem_addr        <= stored_base + MADDR_WIDTH'(req_index);
                        mem_read_enable <= 1'b1;
                        fill_cancelled  <= 1'b0;
                        state           <= FETCH;
                    end
                end
                FETCH: begin
                    if (flush) begin
                        fill_cancelled <= 1'b1;
                    end
                    if (mem_read_ready) begin
                        edge_value      <= mem_data[VALUE_WIDTH-1:0];
                        mem_read_enable <= 1'b0;
                        ready           <= 1'b1;
                        state           <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (flush || (accept && config_changed)) begin
                line_valid <= '0;
            end else if (fill_write) begin
                line_valid[req_line] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clock) begin
        if (fill_write) begin
            line_tag[req_line]  <= req_index;
            line_data[req_line] <= mem_data[VALUE_WIDTH-1:0];
        end
    end

`ifdef EDGE_CACHE_STATS_EN
    // Saturating hit/miss counters, updated when an in-range lookup resolves.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP && !req_out_of_range) begin
            if (lookup_hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_edge_line_cache.sv
// tb_edge_line_cache: directed and random queries against edge_line_cache,
// compared with a behavioural cache model and a synthetic memory image.
// Define EDGE_CACHE_STATS_EN to also check the hit/miss counters.

module tb_edge_line_cache;

    logic        clock;
    logic        reset;
    logic [15:0] base_address;
    logic [7:0]  number_of_nodes;
    logic        flush;
    logic        query_enable;
    logic [7:0]  from_node;
    logic [7:0]  to_node;
    logic        query_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_read_enable;
    logic        mem_read_ready;
    logic        ready;
    logic [15:0] edge_value;
`ifdef EDGE_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit          m_valid [16];
    int          m_tag   [16];
    logic [15:0] m_data  [16];
    int          m_base;
    int          m_n;
    int          m_hits;
    int          m_misses;

    edge_line_cache dut (
        .clock           (clock),
        .reset           (reset),
        .base_address    (base_address),
        .number_of_nodes (number_of_nodes),
        .flush           (flush),
        .query_enable    (query_enable),
        .from_node       (from_node),
        .to_node         (to_node),
        .query_ready     (query_ready),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_read_enable (mem_read_enable),
        .mem_read_ready  (mem_read_ready),
        .ready           (ready),
        .edge_value      (edge_value)
`ifdef EDGE_CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synthetic memory image; address 123 holds 7, upper bits are junk.
    function automatic logic [31:0] mem_image(input logic [15:0] a);
        logic [15:0] lo;
        lo = (a == 16'd123) ? 16'd7 : ((a * 16'd40503) ^ 16'h1234);
        return {a ^ 16'hBEEF, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_base   = 0;
        m_n      = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_stats();
`ifdef EDGE_CACHE_STATS_EN
        check("hit_count", {16'd0, hit_count}, m_hits);
        check("miss_count", {16'd0, miss_count}, m_misses);
`endif
    endtask

    // One query: model predicts, memory answers after lat cycles, result checked.
    task automatic run_query(input int f, input int t, input int lat, input bit flush_in_fetch, input bit poke);
        bit          oor;
        bit          exp_miss;
        int          idx;
        int          line;
        logic [15:0] exp_addr;
        logic [15:0] exp_value;
        int          cyc;
        int          wcnt;
        bit          got;
        bit          saw_re;

        if (base_address != m_base[15:0] || number_of_nodes != m_n[7:0]) model_flush();
        m_base = base_address;
        m_n    = number_of_nodes;
        oor = (f >= m_n) || (t >= m_n);
        idx = f * m_n + t;
        line = idx % 16;
        exp_addr = 16'((m_base + idx) % 65536);
        exp_miss = 1'b0;
        if (oor) begin
            exp_value = 16'hFFFF;
        end else if (m_valid[line] && m_tag[line] == idx) begin
            exp_value = m_data[line];
            m_hits++;
        end else begin
            exp_miss  = 1'b1;
            exp_value = mem_image(exp_addr)[15:0];
            m_misses++;
            if (flush_in_fetch) begin
                model_flush();
            end else begin
                m_valid[line] = 1'b1;
                m_tag[line]   = idx;
                m_data[line]  = exp_value;
            end
        end

        @(negedge clock);
        check("query_ready_idle", {31'd0, query_ready}, 1);
        query_enable = 1'b1;
        from_node    = 8'(f);
        to_node      = 8'(t);
        @(negedge clock);
        query_enable = 1'b0;
        check("query_ready_busy", {31'd0, query_ready}, 0);

        cyc = 0; wcnt = 0; got = 1'b0; saw_re = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clock);
            cyc++;
            mem_read_ready = 1'b0;
            flush          = 1'b0;
            query_enable   = 1'b0;
            mem_data       = $urandom;
            if (ready) begin
                got = 1'b1;
            end else begin
                if (mem_read_enable) begin
                    if (!saw_re && flush_in_fetch) flush = 1'b1;
                    saw_re = 1'b1;
                    if (exp_miss) check("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
                    if (wcnt == lat) begin
                        mem_read_ready = 1'b1;
                        mem_data       = mem_image(mem_addr);
                    end else begin
                        wcnt++;
                    end
                end
                if (poke) begin
                    query_enable = 1'b1;
                    from_node    = 8'($urandom);
                    to_node      = 8'($urandom);
                end
            end
        end
        check("ready_seen", {31'd0, got}, 1);
        check("edge_value", {16'd0, edge_value}, {16'd0, exp_value});
        check("mem_read_seen", {31'd0, saw_re}, {31'd0, exp_miss});
        check("latency", cyc, exp_miss ? lat + 2 : 1);
        @(negedge clock);
        check("ready_one_cycle", {31'd0, ready}, 0);
        check("edge_value_hold", {16'd0, edge_value}, {16'd0, exp_value});
        check_stats();
    endtask

    initial begin
        int f, t, sel;
        bit seen;

        reset           = 1'b0;
        base_address    = 16'd0;
        number_of_nodes = 8'd0;
        flush           = 1'b0;
        query_enable    = 1'b0;
        from_node       = 8'd0;
        to_node         = 8'd0;
        mem_data        = 32'd0;
        mem_read_ready  = 1'b0;
        model_reset();

        #12;
        check("reset_ready", {31'd0, ready}, 0);
        check("reset_mem_read_enable", {31'd0, mem_read_enable}, 0);
        check("reset_mem_addr", {16'd0, mem_addr}, 0);
        check("reset_edge_value", {16'd0, edge_value}, 0);
        check("reset_query_ready", {31'd0, query_ready}, 1);
        check_stats();
        @(negedge clock);
        reset = 1'b1;

        // Basic miss then hit
        base_address    = 16'd100;
        number_of_nodes = 8'd10;
        run_query(2, 3, 3, 1'b0, 1'b0);
        run_query(2, 3, 0, 1'b0, 1'b0);
        // Conflict on line 7
        run_query(3, 9, 1, 1'b0, 1'b0);
        run_query(2, 3, 2, 1'b0, 1'b0);
        // Out-of-range indices
        run_query(10, 0, 0, 1'b0, 1'b0);
        run_query(0, 10, 0, 1'b0, 1'b0);
        // Flush during a fetch blocks the fill
        run_query(1, 1, 2, 1'b1, 1'b0);
        run_query(1, 1, 1, 1'b0, 1'b0);
        run_query(1, 1, 0, 1'b0, 1'b0);
        // Requests while busy are dropped
        run_query(4, 5, 3, 1'b0, 1'b1);
        run_query(4, 5, 0, 1'b0, 1'b1);
        // Address wrap-around with a new base
        base_address = 16'hFFF0;
        run_query(2, 3, 1, 1'b0, 1'b0);
        run_query(2, 3, 1, 1'b0, 1'b0);

        // Random traffic over a few configurations
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 2);
                base_address = (sel == 0) ? 16'd100 : (sel == 1) ? 16'd500 : 16'hFFF0;
            end
            if ($urandom_range(0, 9) == 0) begin
                sel = $urandom_range(0, 2);
                number_of_nodes = (sel == 0) ? 8'd10 : (sel == 1) ? 8'd7 : 8'd4;
            end
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clock);
                flush = 1'b1;
                @(negedge clock);
                flush = 1'b0;
                model_flush();
            end
            f = $urandom_range(0, int'(number_of_nodes));
            t = $urandom_range(0, int'(number_of_nodes));
            if ($urandom_range(0, 3) != 0) begin
                f = f % 3;
                t = t % 3;
            end
            run_query(f, t, $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a fetch
        base_address    = 16'd100;
        number_of_nodes = 8'd10;
        @(negedge clock);
        query_enable = 1'b1;
        from_node    = 8'd5;
        to_node      = 8'd6;
        @(negedge clock);
        query_enable = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = mem_read_enable;
        end
        check("fetch_started", {31'd0, seen}, 1);
        #2 reset = 1'b0;
        #1;
        check("midreset_mem_read_enable", {31'd0, mem_read_enable}, 0);
        check("midreset_ready", {31'd0, ready}, 0);
        check("midreset_mem_addr", {16'd0, mem_addr}, 0);
        check("midreset_edge_value", {16'd0, edge_value}, 0);
        check("midreset_query_ready", {31'd0, query_ready}, 1);
        model_reset();
        @(negedge clock);
        mem_read_ready = 1'b1;
        mem_data       = mem_image(16'd156);
        @(negedge clock);
        mem_read_ready = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("postreset_ready", {31'd0, ready}, 0);
            check("postreset_mem_read_enable", {31'd0, mem_read_enable}, 0);
        end
        check_stats();
        run_query(2, 3, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_line_cache.md
EDGE_LINE_CACHE -- requirements
Module: edge_line_cache

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MAX_NODES, `DEFAULT_MAX_NODES, largest graph supported
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, edge weight width
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width (>= VALUE_WIDTH)
- LINES, 16, cache entries (power of two, >= 2)
REQ-002 Ports SHALL be (name direction width meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- base_address  in  MADDR_WIDTH  adjacency-matrix base
- number_of_nodes  in  INDEX_WIDTH  graph size N
- flush  in  1  invalidate all lines
- query_enable  in  1  query request
- from_node  in  INDEX_WIDTH  row index
- to_node  in  INDEX_WIDTH  column index
- query_ready  out  1  high when a query can be accepted
- mem_addr  out  MADDR_WIDTH  memory read address
- mem_data  in  MDATA_WIDTH  memory read data
- mem_read_enable  out  1  memory read request
- mem_read_ready  in  1  memory data valid
- ready  out  1  one-cycle result strobe
- edge_value  out  VALUE_WIDTH  result weight

Function
REQ-003 Query SHALL be accepted on a rising edge with query_enable=1 and query_ready=1; from_node, to_node, base_address, number_of_nodes sampled then.
REQ-004 States SHALL be IDLE, LOOKUP, FETCH, RESPOND; query_ready=1 only in IDLE.
REQ-005 Edge index SHALL be from_node*number_of_nodes+to_node (2*INDEX_WIDTH bits); mem_addr = base_address + index, truncated modulo 2^MADDR_WIDTH.
REQ-006 Cache SHALL be direct-mapped, LINES entries, each valid bit + full edge index tag + VALUE_WIDTH data; line = index mod LINES.
REQ-007 IDLE->LOOKUP on acceptance; LOOKUP->RESPOND on hit; LOOKUP->FETCH on miss; FETCH->RESPOND on edge with mem_read_ready=1; RESPOND->IDLE always.
REQ-008 Hit latency SHALL be 2 cycles: ready high in the cycle after LOOKUP.
REQ-009 In FETCH, mem_read_enable SHALL be 1 with mem_addr stable until mem_read_ready sampled 1; mem_data[VALUE_WIDTH-1:0] captured and written to the line at that edge.
REQ-010 ready SHALL be high exactly one cycle (RESPOND); edge_value SHALL hold the last result until the next RESPOND.
REQ-011 If from_node>=number_of_nodes or to_node>=number_of_nodes, SHALL go LOOKUP->RESPOND with edge_value all-ones, no memory read, no line update.
REQ-012 If sampled base_address or number_of_nodes differs from the values of the previous accepted query, all lines SHALL be invalidated and the query treated as a miss.
REQ-013 flush SHALL clear all valid bits on the next edge in any state; a fetch in progress completes and returns its data but SHALL NOT write the line; flush takes priority over a same-edge fill.
REQ-014 query_enable while query_ready=0 SHALL be ignored (not queued).

Reset
REQ-015 reset low SHALL immediately force IDLE, clear all valid bits and stored base/N, ready=0, mem_read_enable=0, mem_addr=0, edge_value=0, query_ready=1 after release; an outstanding fetch is abandoned.

Configuration
REQ-016 Macro EDGE_CACHE_STATS_EN defined: adds outputs hit_count and miss_count (16 bits each, out), incremented at LOOKUP on hit/miss, saturating at 16'hFFFF, cleared by reset, not by flush; out-of-range queries count neither.
REQ-017 EDGE_CACHE_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-018 Scenarios:
- base=100, N=10, query (2,3), memory returns 7 after 3 cycles -> mem_addr=123, ready with edge_value=7.
- Repeat query (2,3) -> no mem_read_enable, ready 2 cycles after acceptance, edge_value=7 (hit_count=1 with stats).
- Query (2,3) then (3,9) with LINES=16 (indices 23, 39 collide on line 7) then (2,3) -> third query misses, reads addr 123 again.
- Query (10,0) with N=10 -> ready, edge_value all-ones, mem_read_enable never asserted.
- Assert flush during FETCH of (1,1), then query (1,1) -> first returns data, second misses and re-reads addr 111.
- reset low mid-FETCH -> mem_read_enable=0 immediately, ready never asserted, next query (2,3) misses.
